// File: rtl/audio_dac_if.sv
// Sample stream from the AM demodulator into the audio output stage:
// one-cycle in_tick strobe qualifying a signed in_sample.
`timescale 1ns / 1ps

interface audio_dac_if #(
  parameter int unsigned IN_W = 16
) ();
  logic [IN_W-1:0] in_sample;
  logic            in_tick;

  modport master (output in_sample, output in_tick);
  modport slave  (input  in_sample, input  in_tick);
endinterface

// File: rtl/audio_dac.sv
// Audio output stage: sample FIFO, power-of-two gain with saturation, PWM output pin.
// Define AUDIO_SDM_EN to build the first-order sigma-delta modulator selected by mode.
`timescale 1ns / 1ps

module audio_dac #(
  parameter int unsigned IN_W       = 16,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             RST,
  audio_dac_if.slave       src,
  input  logic [3:0]       shift,
  input  logic             mode,
  input  logic             clr_status,
  output logic             pwm_out,
  output logic [PWM_W-1:0] duty,
  output logic             underrun,
  output logic             overrun
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned GW    = IN_W + 15;

  logic [IN_W-1:0]       mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [PWM_W-1:0]      cnt_q, cnt_d;
  logic [PWM_W-1:0]      duty_q, duty_d;
  logic                  pwm_q, pwm_d;
  logic                  underrun_q, underrun_d;
  logic                  overrun_q, overrun_d;

  logic period_end, full, empty, pop, push;

  assign period_end = (cnt_q == {PWM_W{1'b1}});
  // count never exceeds Depth, so its MSB alone marks full
  assign full       = count_q[DEPTH_LOG2];
  assign empty      = (count_q == '0);
  assign pop        = period_end & ~empty;
  assign push       = src.in_tick & (~full | pop);

  // Gain and saturation on the FIFO head
  logic [IN_W-1:0]        head;
  logic signed [GW-1:0]   g_ext, g;
  logic [GW-IN_W:0]       g_hi;
  logic [PWM_W-1:0]       sat_top;
  logic [PWM_W-1:0]       code;
  logic                   unused_low;

  assign head       = mem_q[rd_ptr_q];
  assign unused_low = ^g[IN_W-PWM_W-1:0];

  always_comb begin
    g_ext   = {{15{head[IN_W-1]}}, head};
    g       = g_ext <<< shift;
    g_hi    = g[GW-1:IN_W-1];
    sat_top = g[IN_W-1 -: PWM_W];
    if (!(&g_hi) && (|g_hi)) begin
      sat_top = g[GW-1] ? {1'b1, {(PWM_W-1){1'b0}}} : {1'b0, {(PWM_W-1){1'b1}}};
    end
    // offset binary: flip the sign bit
    code = sat_top ^ {1'b1, {(PWM_W-1){1'b0}}};
  end

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    duty_d     = pop ? code : duty_q;
    // set wins over a coincident clear
    underrun_d = (period_end & empty) | (underrun_q & ~clr_status);
    overrun_d  = (src.in_tick & full & ~pop) | (overrun_q & ~clr_status);
  end

`ifdef AUDIO_SDM_EN
  logic [PWM_W:0] acc_q, acc_d;
  logic           mode_q, mode_d;

  always_comb begin
    acc_d  = {1'b0, acc_q[PWM_W-1:0]} + {1'b0, duty_q};
    mode_d = pop ? mode : mode_q;
  end

  assign pwm_d = mode_q ? acc_q[PWM_W] : (cnt_q < duty_q);

  always_ff @(posedge clk) begin
    if (RST) begin
      acc_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      mode_q <= mode_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign pwm_d       = (cnt_q < duty_q);
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      duty_q     <= {1'b1, {(PWM_W-1){1'b0}}};
      pwm_q      <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST && push) begin
      mem_q[wr_ptr_q] <= src.in_sample;
    end
  end

  assign pwm_out  = pwm_q;
  assign duty     = duty_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_audio_dac.sv
// Directed bench for audio_dac: expected duty codes queued at each tick, checked at each wrap.
`timescale 1ns / 1ps

module tb_audio_dac;
  localparam int unsigned IN_W       = 16;
  localparam int unsigned PWM_W      = 8;
  localparam int unsigned DEPTH_LOG2 = 2;

  logic             clk = 1'b0;
  logic             RST;
  logic [3:0]       shift;
  logic             mode;
  logic             clr_status;
  logic             pwm_out;
  logic [PWM_W-1:0] duty;
  logic             underrun;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  logic [PWM_W-1:0] phase;
  logic [PWM_W-1:0] exp_q [$];
  logic [PWM_W-1:0] last_duty;

  audio_dac_if #(.IN_W(IN_W)) bus ();

  audio_dac #(
    .IN_W      (IN_W),
    .PWM_W     (PWM_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .src       (bus),
    .shift     (shift),
    .mode      (mode),
    .clr_status(clr_status),
    .pwm_out   (pwm_out),
    .duty      (duty),
    .underrun  (underrun),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // reference period counter, independent of the DUT
  always @(posedge clk) phase <= RST ? '0 : phase + 1'b1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [PWM_W-1:0] exp_duty(input logic [15:0] s, input int sh);
    int     sv;
    longint v;
    sv = int'($signed(s));
    v  = longint'(sv) * (longint'(1) << sh);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return PWM_W'((v >>> 8) + 128);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [15:0] s, input bit accept);
    bus.in_sample = s;
    bus.in_tick   = 1'b1;
    @(negedge clk);
    bus.in_tick   = 1'b0;
    if (accept) exp_q.push_back(exp_duty(s, int'(shift)));
  endtask

  task automatic to_wrap();
    while (phase != {PWM_W{1'b1}}) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_wrap(input string tag);
    to_wrap();
    if (exp_q.size() > 0) begin
      last_duty = exp_q.pop_front();
      check(tag, duty, last_duty);
    end else begin
      check({tag, "_underrun"}, underrun, 1);
      check({tag, "_held"}, duty, last_duty);
    end
  endtask

  task automatic count_period(output int ones);
    ones = 0;
    repeat (256) begin
      @(negedge clk);
      ones += int'(pwm_out);
    end
  endtask

  task automatic clear_flags();
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  initial begin
    int ones;
    int adj;
    logic prev;

    RST           = 1'b1;
    bus.in_tick   = 1'b0;
    bus.in_sample = '0;
    shift         = 4'd0;
    mode          = 1'b0;
    clr_status    = 1'b0;
    last_duty     = 8'h80;
    repeat (3) @(negedge clk);
    check("rst_duty", duty, 8'h80);
    check("rst_pwm", pwm_out, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overrun", overrun, 0);
    RST = 1'b0;

    // idle: mid-scale silence, underrun after the first wrap
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ones += int'(pwm_out);
      if (i == 254) check("underrun_before_wrap", underrun, 0);
    end
    check("idle_ones_p0", ones, 128);
    check("underrun_after_wrap", underrun, 1);
    check("idle_duty", duty, 8'h80);
    repeat (2) begin
      count_period(ones);
      check("idle_ones", ones, 128);
    end
    clear_flags();
    check("clr_underrun", underrun, 0);

    // basic gain paths
    tick(16'h4000, 1'b1);
    chk_wrap("duty_c0");
    count_period(ones);
    check("ones_c0", ones, 192);

    shift = 4'd3;
    tick(16'h2000, 1'b1);
    chk_wrap("sat_pos");
    count_period(ones);
    check("ones_ff", ones, 255);

    shift = 4'd2;
    tick(16'hC000, 1'b1);
    chk_wrap("sat_neg");
    count_period(ones);
    check("ones_00", ones, 0);

    // five ticks into a 4-deep FIFO
    shift = 4'd0;
    clear_flags();
    check("clr2_underrun", underrun, 0);
    check("clr2_overrun", overrun, 0);
    tick(16'h1000, 1'b1);
    tick(16'h2000, 1'b1);
    tick(16'h3000, 1'b1);
    tick(16'h4000, 1'b1);
    check("no_overrun_at_4", overrun, 0);
    tick(16'h5000, 1'b0);
    check("overrun_at_5", overrun, 1);
    repeat (4) chk_wrap("fifo_order");
    check("overrun_sticky", overrun, 1);
    chk_wrap("drain");
    clear_flags();
    check("clr3_underrun", underrun, 0);
    check("clr3_overrun", overrun, 0);

    // full FIFO with a tick on the wrap cycle: pop and push together
    tick(16'h0800, 1'b1);
    tick(16'h1800, 1'b1);
    tick(16'h2800, 1'b1);
    tick(16'h3800, 1'b1);
    while (phase != {PWM_W{1'b1}}) @(negedge clk);
    tick(16'h4800, 1'b1);
    check("wrap_tick_no_overrun", overrun, 0);
    last_duty = exp_q.pop_front();
    check("wrap_tick_duty", duty, last_duty);
    tick(16'h5800, 1'b0);
    check("still_full_overrun", overrun, 1);
    repeat (4) chk_wrap("full_order");
    chk_wrap("full_drain");
    clear_flags();

`ifdef AUDIO_SDM_EN
    mode = 1'b1;
    tick(16'hC000, 1'b1);
    chk_wrap("sdm_duty_40");
    count_period(ones);
    prev = pwm_out;
    ones = 0;
    adj  = 0;
    repeat (256) begin
      @(negedge clk);
      ones += int'(pwm_out);
      if (pwm_out && prev) adj++;
      prev = pwm_out;
    end
    check("sdm_ones", ones, 64);
    check("sdm_adjacent", adj, 0);
`endif

    // reset mid-period discards buffered samples
    tick(16'h4000, 1'b1);
    tick(16'h6000, 1'b1);
    repeat (50) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check("midrst_pwm", pwm_out, 0);
    check("midrst_duty", duty, 8'h80);
    check("midrst_underrun", underrun, 0);
    check("midrst_overrun", overrun, 0);
    RST = 1'b0;
    exp_q.delete();
    last_duty = 8'h80;
    chk_wrap("post_reset");
    count_period(ones);
    check("post_reset_ones", ones, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
